rom_stream_reader: RTL and testbench
====================================

Name: rom_stream_reader

Overview:
- Upstream/downstream companion of the 8x8 synchronous ROM: walks ROM addresses and drives the ROM's address and enable.
- Captures the registered ROM output.
- Presents the words on a valid/ready stream with a 2-entry output buffer, so downstream backpressure never drops or duplicates a word.
- Sits between a control master (start/count) and any stream consumer.

Parameters:
ADDR_W, 3, ROM address width; ROM depth = 2**ADDR_W
DATA_W, 8, ROM word width
CNT_W, 4, width of the burst length input (ADDR_W+1, allows a full 8-word burst)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a burst; sampled only in IDLE
start_addr  in  ADDR_W  first ROM address of the burst
count  in  CNT_W  number of words to read, 0..8
busy  out  1  high from the cycle after an accepted start until the done cycle inclusive
done  out  1  one-cycle pulse after the final word is accepted downstream
rom_addr  out  ADDR_W  address to ROM
rom_en  out  1  ROM read enable; one read per cycle it is high
rom_data  in  DATA_W  ROM registered output, valid 1 cycle after the rom_en cycle
out_data  out  DATA_W  stream data (head of the output buffer)
out_valid  out  1  stream valid
out_ready  in  1  stream ready from consumer
out_last  out  1  high with the final word of a burst

Behaviour:
- Reset, applied at any time including mid-burst:
  - Outputs: busy=0, done=0, rom_en=0, rom_addr=0, out_valid=0, out_last=0, out_data=0.
  - Buffer flushed, counters cleared, FSM to IDLE.
  - Read data returning in the cycle after reset is discarded.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: when start=1 and count!=0, latch start_addr/count and go to READ.
  - IDLE: when start=1 and count=0, go to DONE with no ROM reads and no stream words.
  - READ: issue reads until count reads have been issued, then go to DRAIN.
  - DRAIN: when the last word is accepted (out_valid & out_ready & out_last), go to DONE.
  - DONE: done=1 for exactly one cycle, busy=1 that cycle, then IDLE.
  - start is ignored in every state except IDLE.
- Read issue, in READ:
  - rom_en=1 only when (buffer occupancy + reads in flight) < 2, so at most 2 words are ever owed to the buffer.
  - The first read is issued in the first READ cycle.
  - rom_addr = start_addr + issued_count, mod 2**ADDR_W. Wrap 7 -> 0 is legal.
  - rom_en=0 in all other states; rom_addr holds its last value.
- Capture: the word for a read issued in cycle N is written to the buffer at the end of cycle N+1.
- Output buffer: 2-entry FIFO, out_data = head entry.
  - out_valid = buffer not empty.
  - A pop occurs when out_valid & out_ready.
  - Simultaneous push and pop in one cycle is legal; occupancy is unchanged.
- Throughput: with out_ready held high, one word per cycle. The first out_valid appears 2 cycles after the start cycle.
- out_last: high exactly while the head entry is the count-th word of the burst.
- Stream rules:
  - Once out_valid=1, out_data/out_last hold stable until the word is accepted.
  - out_valid never deasserts without a pop.
- Latency, count=N with ready always high:
  - start at cycle 0; words out in cycles 2..N+1; done in cycle N+2; busy in cycles 1..N+2.

Test Plan:
- ROM holds mem[i]=8'h10+i. start_addr=0, count=8, out_ready=1 -> words 10..17 in 8 consecutive cycles, out_last with 17, done 1 cycle later, rom_en high for 8 cycles.
- start_addr=6, count=4 -> rom_addr 6,7,0,1; words 16,17,10,11; out_last on 11.
- count=3, out_ready toggles 1,0,0,1,0,1,... -> each word delivered exactly once, in order. Data is stable while stalled. Occupancy+in-flight never exceeds 2 (assertion).
- count=0 start -> no rom_en, no out_valid, done pulse in the cycle after start, busy high only that cycle.
- Mid-burst rst after 2 words are accepted, with out_ready=0 -> next cycle all outputs at reset values. A fresh start_addr=2, count=2 then yields 12,13 only.
- start pulsed again while busy -> ignored: the current burst completes unchanged and exactly one done pulse is produced.

Source files
------------

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - walks a synchronous ROM for a start/count burst and streams the words out
// through a 2-entry buffer that absorbs downstream backpressure without dropping or repeating words.
module rom_stream_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  popped_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              inflight_q;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;

  logic accept;
  logic room;
  logic final_issue;
  logic pop;
  logic last_pop;
  logic store;
  logic pop_fifo;
  logic [DATA_W-1:0] head_data;

  assign accept      = (state_q == S_IDLE) && start;
  // Words owed to the buffer: stored entries plus the read whose data arrives this cycle.
  assign room        = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2;
  assign final_issue = rom_en && (issued_q == count_q - CNT_W'(1));
  assign pop         = out_valid && out_ready;
  assign last_pop    = pop && out_last;

  // An arriving word that is consumed straight away while the buffer is empty is never stored.
  assign store    = inflight_q && !((occ_q == 2'd0) && pop);
  assign pop_fifo = pop && (occ_q != 2'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (final_issue) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_pop) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    rom_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_READ: begin
        busy   = 1'b1;
        rom_en = room;
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Burst bookkeeping and ROM address walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      rom_addr_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rom_en;
      if (accept) begin
        count_q  <= count;
        issued_q <= '0;
        popped_q <= '0;
        if (count != '0) begin
          rom_addr_q <= start_addr;
        end
      end
      if (rom_en) begin
        issued_q <= issued_q + CNT_W'(1);
        // After the final read the address stays on the last word fetched.
        if (!final_issue) begin
          rom_addr_q <= rom_addr_q + ADDR_W'(1);
        end
      end
      if (pop) begin
        popped_q <= popped_q + CNT_W'(1);
      end
    end
  end

  // Two-entry output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      if (store) begin
        fifo_mem[wr_ptr_q] <= rom_data;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop_fifo) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({store, pop_fifo})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_data = (occ_q != 2'd0) ? fifo_mem[rd_ptr_q] : rom_data;
  assign out_valid = (occ_q != 2'd0) || inflight_q;
  assign out_data  = out_valid ? head_data : '0;
  assign out_last  = out_valid && (popped_q == count_q - CNT_W'(1));
  assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb/tb_rom_stream_reader.sv - scoreboard bench for rom_stream_reader with an 8x8 registered ROM model
// (mem[i] = 8'h10 + i).
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] start_addr = '0;
  logic [3:0] count = '0;
  logic       busy;
  logic       done;
  logic [2:0] rom_addr;
  logic       rom_en;
  logic [7:0] rom_data = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;

  rom_stream_reader #(.ADDR_W(3), .DATA_W(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_en     (rom_en),
    .rom_data   (rom_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_en) rom_data <= 8'h10 + {5'd0, rom_addr};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] addr_q[$];
  exp_t       e;

  int tests = 0;
  int fails = 0;

  int rdy_mode = 0;
  int pidx = 0;
  bit [5:0] pat = 6'b101001;

  bit         chk_addr = 1'b1;
  int         done_cnt, done_cyc, busy_cnt, en_cnt, valid_cnt, pend, max_pend;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_le(input string name, input int act, input int lim);
    tests++;
    if (act > lim) begin
      fails++;
      $display("FAIL %s: got %0d, expected at most %0d", name, act, lim);
    end
  endtask

  // pat[0..5] = 1,0,0,1,0,1
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = pat[pidx];
        pidx = (pidx + 1) % 6;
      end
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
      prev_stall = 1'b0;
    end else begin
      if (rom_en) begin
        en_cnt++;
        pend++;
        if (chk_addr) begin
          if (addr_q.size() == 0) chk("unexpected_rom_read", 1, 0);
          else chk("rom_addr", rom_addr, addr_q.pop_front());
        end
      end
      if (pend > max_pend) max_pend = pend;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        pend--;
        if (sb_q.size() == 0) begin
          chk("unexpected_word", out_data, -1);
        end else begin
          e = sb_q.pop_front();
          chk("word_data", out_data, e.data);
          chk("word_last", out_last, e.last);
          if (e.cyc >= 0) chk("word_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic check_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
  endtask

  task automatic clear_counters();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; en_cnt = 0; valid_cnt = 0; max_pend = 0;
  endtask

  task automatic run_burst(input int addr, input int cnt, input int mode, input bit extra);
    int c;
    @(negedge clk);
    rdy_mode = mode;
    @(posedge clk); #1;
    c = cyc;
    clear_counters();
    chk_addr = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      e.data = 8'h10 + 8'((addr + i) % 8);
      e.last = (i == cnt - 1);
      e.cyc  = (mode == 0) ? c + 2 + i : -1;
      sb_q.push_back(e);
      addr_q.push_back(3'((addr + i) % 8));
    end
    start = 1'b1; start_addr = 3'(addr); count = 4'(cnt);
    @(posedge clk); #1;
    start = 1'b0; start_addr = '0; count = '0;
    if (extra) begin
      @(posedge clk); #1;
      start = 1'b1; start_addr = 3'd7; count = 4'd2;
      @(posedge clk); #1;
      start = 1'b0; start_addr = '0; count = '0;
    end
    for (int k = 0; k < 200 && done_cnt == 0; k++) @(posedge clk);
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("rom_reads", en_cnt, cnt);
    chk("words_left", sb_q.size(), 0);
    chk("addrs_left", addr_q.size(), 0);
    chk_le("owed_words", max_pend, 2);
    if (mode == 0) begin
      chk("done_cycle", done_cyc, (cnt == 0) ? c + 1 : c + cnt + 2);
      chk("busy_cycles", busy_cnt, (cnt == 0) ? 1 : cnt + 2);
      chk("valid_cycles", valid_cnt, cnt);
    end
    sb_q.delete();
    addr_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    clear_counters();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    run_burst(0, 8, 0, 1'b0);
    run_burst(6, 4, 0, 1'b0);
    run_burst(5, 3, 1, 1'b0);
    run_burst(0, 0, 0, 1'b0);
    run_burst(1, 4, 0, 1'b1);

    // Mid-burst reset: two words accepted, then a stall, then reset.
    @(negedge clk);
    rdy_mode = 0;
    @(posedge clk); #1;
    c = cyc;
    clear_counters();
    chk_addr = 1'b0;
    e.data = 8'h10; e.last = 1'b0; e.cyc = c + 2; sb_q.push_back(e);
    e.data = 8'h11; e.last = 1'b0; e.cyc = c + 3; sb_q.push_back(e);
    start = 1'b1; start_addr = 3'd0; count = 4'd8;
    @(posedge clk); #1;
    start = 1'b0; count = '0;
    repeat (3) @(negedge clk);
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    chk("mid_rst_words_left", sb_q.size(), 0);
    sb_q.delete();
    run_burst(2, 2, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
